io_input_conditioner: RTL

- Conditions the raw board inputs KEY[3:0] and SW[9:0] before they reach the memory-mapped IO registers in the memory stage.
- Each bit is synchronised, debounced and converted to active-high.
- Key presses are captured as sticky edge flags that software clears through a strobe from the IO controller.
- Outputs are zero-extended DBITS-wide words that load directly into the memory stage's KEY/SW registers.

---
 rtl/io_input_conditioner.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/io_input_conditioner.sv
// io_input_conditioner
// Synchronises, debounces and polarity-corrects the raw KEY/SW board inputs,
// captures key presses as sticky edge flags with a masked software clear, and
// presents everything as zero-extended words for the memory-stage IO registers.
// Internal bit ordering of the debounce bank: [3:0] = KEY, [13:4] = SW.

module io_input_conditioner #(
   parameter int DBITS           = 32,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_BITS        = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       KEY,
   input  logic [9:0]       SW,
   input  logic             keyEdgeClr,
   input  logic [3:0]       keyEdgeClrMask,
   output logic [DBITS-1:0] keyOut,
   output logic [DBITS-1:0] swOut,
   output logic [DBITS-1:0] keyEdgeOut,
   output logic             keyIrq
);

   localparam int NBITS = 14;
   localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } db_state_e;

   // two-flop synchronisers
   logic [3:0]        key_meta_q, key_meta_d;
   logic [3:0]        key_sync_q, key_sync_d;
   logic [9:0]        sw_meta_q, sw_meta_d;
   logic [9:0]        sw_sync_q, sw_sync_d;
   logic [NBITS-1:0]  synced_s;

   // debounce bank
   db_state_e         state_q [NBITS];
   db_state_e         state_d [NBITS];
   logic [CNT_BITS-1:0] cnt_q [NBITS];
   logic [CNT_BITS-1:0] cnt_d [NBITS];
   logic [NBITS-1:0]  stable_q, stable_d;
   logic [NBITS-1:0]  accept_s;

   // edge capture and interrupt
   logic [3:0]        key_rise_s;
   logic [3:0]        clr_s;
   logic [3:0]        key_edge_q, key_edge_d;
   logic              key_irq_q, key_irq_d;

   // Next values of the synchroniser chains: each flop takes its predecessor.
   always_comb begin
      key_meta_d = KEY;
      key_sync_d = key_meta_q;
      sw_meta_d  = SW;
      sw_sync_d  = sw_meta_q;
   end

   // Synchroniser flops; keys reset to released (1), switches to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_meta_q <= 4'hF;
         key_sync_q <= 4'hF;
         sw_meta_q  <= 10'h000;
         sw_sync_q  <= 10'h000;
      end else begin
         key_meta_q <= key_meta_d;
         key_sync_q <= key_sync_d;
         sw_meta_q  <= sw_meta_d;
         sw_sync_q  <= sw_sync_d;
      end
   end

   // Synchronised view of all inputs, keys inverted to active-high.
   always_comb begin
      synced_s = {sw_sync_q, ~key_sync_q};
   end

   // Debounce next-state logic: a new value must persist for the full count,
   // and any return to the accepted value abandons the count.
   always_comb begin
      stable_d = stable_q;
      accept_s = {NBITS{1'b0}};
      for (int i = 0; i < NBITS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_STABLE: begin
               if (synced_s[i] != stable_q[i]) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     // A one-cycle window accepts on the first differing sample.
                     stable_d[i] = synced_s[i];
                     accept_s[i] = 1'b1;
                     cnt_d[i]    = CNT_ZERO;
                  end else begin
                     state_d[i] = ST_COUNTING;
                     cnt_d[i]   = CNT_ONE;
                  end
               end else begin
                  cnt_d[i] = CNT_ZERO;
               end
            end
            ST_COUNTING: begin
               if (synced_s[i] == stable_q[i]) begin
                  state_d[i] = ST_STABLE;
                  cnt_d[i]   = CNT_ZERO;
               end else if (cnt_q[i] == CNT_MAX) begin
                  state_d[i]  = ST_STABLE;
                  cnt_d[i]    = CNT_ZERO;
                  stable_d[i] = synced_s[i];
                  accept_s[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            default: begin
               state_d[i] = ST_STABLE;
               cnt_d[i]   = CNT_ZERO;
            end
         endcase
      end
   end

   // Debounce state, counters and accepted values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NBITS; i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= CNT_ZERO;
         end
         stable_q <= {NBITS{1'b0}};
      end else begin
         for (int i = 0; i < NBITS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         stable_q <= stable_d;
      end
   end

   // Masked clear strobe: only active on a keyEdgeClr cycle.
   always_comb begin
      if (keyEdgeClr) begin
         clr_s = keyEdgeClrMask;
      end else begin
         clr_s = 4'h0;
      end
   end

   // Sticky press flags: set on an accepted 0->1 key transition, and the set
   // term is ORed last so a press arriving with a clear is never lost.
   always_comb begin
      key_rise_s = accept_s[3:0] & synced_s[3:0];
      key_edge_d = (key_edge_q & ~clr_s) | key_rise_s;
      key_irq_d  = |key_edge_q;
   end

   // Edge flag and interrupt registers; the interrupt trails the flags by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_edge_q <= 4'h0;
         key_irq_q  <= 1'b0;
      end else begin
         key_edge_q <= key_edge_d;
         key_irq_q  <= key_irq_d;
      end
   end

   // Zero-extended output words driven straight from registers.
   always_comb begin
      keyOut     = {{(DBITS-4){1'b0}}, stable_q[3:0]};
      swOut      = {{(DBITS-10){1'b0}}, stable_q[13:4]};
      keyEdgeOut = {{(DBITS-4){1'b0}}, key_edge_q};
      keyIrq     = key_irq_q;
   end

endmodule
